// File: rtl/galaxian_dl_pkg.sv
// Shared types and sizing for the Galaxian ROM download controller.
package galaxian_dl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_HOLD,
    ST_RUN,
    ST_ERR
  } state_e;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_CPU,
    REG_GFX,
    REG_PROM
  } region_e;

  localparam int unsigned IOCTL_ADDR_W = 25;
  localparam int unsigned DN_ADDR_W    = 16;
  localparam int unsigned DN_DATA_W    = 8;
  localparam int unsigned COUNT_W      = 17;

  localparam int unsigned CPU_ROM_SIZE_DEF = 16384;
  localparam int unsigned GFX_BASE_DEF     = 16384;
  localparam int unsigned GFX_SIZE_DEF     = 4096;
  localparam int unsigned PROM_BASE_DEF    = 20480;
  localparam int unsigned PROM_SIZE_DEF    = 32;
  localparam int unsigned HOLD_CYCLES_DEF  = 1024;

  function automatic int unsigned expected_len(input int unsigned cpu_size,
                                               input int unsigned gfx_size,
                                               input int unsigned prom_size);
    return cpu_size + gfx_size + prom_size;
  endfunction

  localparam int unsigned EXPECTED_LEN =
    expected_len(CPU_ROM_SIZE_DEF, GFX_SIZE_DEF, PROM_SIZE_DEF);

endpackage

// File: rtl/galaxian_dl_decode.sv
// Maps an ioctl byte address onto a target region and a region-relative address.
module galaxian_dl_decode
  import galaxian_dl_pkg::*;
#(
  parameter int unsigned CPU_ROM_SIZE = CPU_ROM_SIZE_DEF,
  parameter int unsigned GFX_BASE     = GFX_BASE_DEF,
  parameter int unsigned GFX_SIZE     = GFX_SIZE_DEF,
  parameter int unsigned PROM_BASE    = PROM_BASE_DEF,
  parameter int unsigned PROM_SIZE    = PROM_SIZE_DEF
) (
  input  logic [IOCTL_ADDR_W-1:0] addr,
  output region_e                 region_c,
  output logic [DN_ADDR_W-1:0]    rel_addr_c
);

  // Anything outside the three windows, high address bits included, is REG_NONE.
  always_comb begin
    region_c   = REG_NONE;
    rel_addr_c = '0;
    if (addr < IOCTL_ADDR_W'(CPU_ROM_SIZE)) begin
      region_c   = REG_CPU;
      rel_addr_c = DN_ADDR_W'(addr);
    end else if (addr >= IOCTL_ADDR_W'(GFX_BASE) &&
                 addr <  IOCTL_ADDR_W'(GFX_BASE + GFX_SIZE)) begin
      region_c   = REG_GFX;
      rel_addr_c = DN_ADDR_W'(addr - IOCTL_ADDR_W'(GFX_BASE));
    end else if (addr >= IOCTL_ADDR_W'(PROM_BASE) &&
                 addr <  IOCTL_ADDR_W'(PROM_BASE + PROM_SIZE)) begin
      region_c   = REG_PROM;
      rel_addr_c = DN_ADDR_W'(addr - IOCTL_ADDR_W'(PROM_BASE));
    end
  end

endmodule

// File: rtl/galaxian_dl_ctrl.sv
// Steers the HPS download into the Galaxian ROMs, validates the image and
// sequences the core reset around each load.
module galaxian_dl_ctrl
  import galaxian_dl_pkg::*;
#(
  parameter int unsigned CPU_ROM_SIZE = CPU_ROM_SIZE_DEF,
  parameter int unsigned GFX_BASE     = GFX_BASE_DEF,
  parameter int unsigned GFX_SIZE     = GFX_SIZE_DEF,
  parameter int unsigned PROM_BASE    = PROM_BASE_DEF,
  parameter int unsigned PROM_SIZE    = PROM_SIZE_DEF,
  parameter int unsigned HOLD_CYCLES  = HOLD_CYCLES_DEF
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic                    ioctl_download,
  input  logic                    ioctl_wr,
  input  logic [IOCTL_ADDR_W-1:0] ioctl_addr,
  input  logic [DN_DATA_W-1:0]    ioctl_dout,
  output logic [DN_ADDR_W-1:0]    dn_addr,
  output logic [DN_DATA_W-1:0]    dn_data,
  output logic                    cpu_rom_we,
  output logic                    gfx_rom_we,
  output logic                    prom_we,
  output logic                    core_reset,
  output logic [COUNT_W-1:0]      byte_count,
  output logic                    load_ok,
  output logic                    load_err
);

  localparam int unsigned EXP_LEN = expected_len(CPU_ROM_SIZE, GFX_SIZE, PROM_SIZE);
  localparam int unsigned HOLD_W  = $clog2(HOLD_CYCLES + 1);

  state_e                state;
  logic                  dl_q;
  logic                  ovf;
  logic [HOLD_W-1:0]     hold_cnt;
  region_e               dec_region_c;
  logic [DN_ADDR_W-1:0]  dec_rel_c;
  logic                  rise_c;
  logic                  fall_c;
  logic                  accept_c;

  galaxian_dl_decode #(
    .CPU_ROM_SIZE (CPU_ROM_SIZE),
    .GFX_BASE     (GFX_BASE),
    .GFX_SIZE     (GFX_SIZE),
    .PROM_BASE    (PROM_BASE),
    .PROM_SIZE    (PROM_SIZE)
  ) u_decode (
    .addr       (ioctl_addr),
    .region_c   (dec_region_c),
    .rel_addr_c (dec_rel_c)
  );

  assign rise_c = ioctl_download & ~dl_q;
  assign fall_c = ~ioctl_download & dl_q;
  // dl_q keeps the write in the falling cycle valid while download is already low.
  assign accept_c = ioctl_wr & (ioctl_download | dl_q);

  // dl_q follows the input even in reset, so a download held across reset is not a new rise.
  always_ff @(posedge clk_sys) begin
    dl_q       <= ioctl_download;
    cpu_rom_we <= 1'b0;
    gfx_rom_we <= 1'b0;
    prom_we    <= 1'b0;
    if (reset) begin
      state      <= ST_IDLE;
      core_reset <= 1'b1;
      dn_addr    <= '0;
      dn_data    <= '0;
      byte_count <= '0;
      load_ok    <= 1'b0;
      load_err   <= 1'b0;
      hold_cnt   <= '0;
      ovf        <= 1'b0;
    end else if (rise_c && state != ST_LOAD) begin
      state      <= ST_LOAD;
      core_reset <= 1'b1;
      byte_count <= '0;
      ovf        <= 1'b0;
      load_ok    <= 1'b0;
      load_err   <= 1'b0;
      hold_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: core_reset <= 1'b1;
        ST_LOAD: begin
          core_reset <= 1'b1;
          if (accept_c) begin
            if (dec_region_c != REG_NONE) begin
              dn_addr    <= dec_rel_c;
              dn_data    <= ioctl_dout;
              cpu_rom_we <= (dec_region_c == REG_CPU);
              gfx_rom_we <= (dec_region_c == REG_GFX);
              prom_we    <= (dec_region_c == REG_PROM);
              if (byte_count != '1) byte_count <= byte_count + COUNT_W'(1);
            end else begin
              ovf <= 1'b1;
            end
          end
          if (fall_c) state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (!ovf && byte_count == COUNT_W'(EXP_LEN)) begin
            state    <= ST_HOLD;
            hold_cnt <= '0;
          end else begin
            state    <= ST_ERR;
            load_err <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
            state      <= ST_RUN;
            core_reset <= 1'b0;
            load_ok    <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        ST_RUN:  core_reset <= 1'b0;
        ST_ERR:  core_reset <= 1'b1;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/galaxian_dl_ctrl.md
Name: galaxian_dl_ctrl

Overview:
Sequences the HPS ROM download stream into the Galaxian core's memories and owns the core's reset during and after a load. Decodes each ioctl byte into one of three regions: CPU ROM, graphics ROM and colour PROM. Registers the write towards the selected region and counts accepted bytes. After the download it validates the image length, holds the core in reset for a settling period, then releases it, or latches an error.
Sits between hps_io ioctl outputs and the galaxian dn_* / I_RESET inputs.

Parameters:
CPU_ROM_SIZE, 16384, bytes in CPU ROM region; region starts at 0x0000.
GFX_BASE, 16384, first byte address of graphics ROM region.
GFX_SIZE, 4096, bytes in graphics ROM region.
PROM_BASE, 20480, first byte address of colour PROM region.
PROM_SIZE, 32, bytes in colour PROM region.
HOLD_CYCLES, 1024, clk_sys cycles core_reset stays high after a good load.

Ports:
clk_sys  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-high.
ioctl_download  in  1  download in progress (level).
ioctl_wr  in  1  one-cycle byte strobe.
ioctl_addr  in  25  byte address.
ioctl_dout  in  8  byte data.
dn_addr  out  16  registered address, region-relative.
dn_data  out  8  registered data.
cpu_rom_we  out  1  one-cycle write enable, CPU ROM.
gfx_rom_we  out  1  one-cycle write enable, graphics ROM.
prom_we  out  1  one-cycle write enable, colour PROM.
core_reset  out  1  reset to core (OR'd with user reset outside).
byte_count  out  17  accepted in-range bytes this load, saturating at 0x1FFFF.
load_ok  out  1  level, last load valid and core released.
load_err  out  1  level, last load invalid.

Behaviour:
- Reset values:
  - state IDLE
  - core_reset=1
  - all *_we=0
  - dn_addr=0, dn_data=0
  - byte_count=0
  - load_ok=0, load_err=0
  - hold counter=0
  - overflow flag=0
- Input edge detection: dl_q is ioctl_download registered. Rise = ioctl_download & ~dl_q. Fall = ~ioctl_download & dl_q.
- States: IDLE, LOAD, CHECK, HOLD, RUN, ERR.
- IDLE: core_reset=1. Rise -> LOAD.
- LOAD: core_reset=1.
  - Entering LOAD clears byte_count, the overflow flag, load_ok and load_err.
  - Each ioctl_wr with ioctl_download=1 is decoded:
    - addr < CPU_ROM_SIZE -> cpu_rom_we, dn_addr=addr.
    - GFX_BASE <= addr < GFX_BASE+GFX_SIZE -> gfx_rom_we, dn_addr=addr-GFX_BASE.
    - PROM_BASE <= addr < PROM_BASE+PROM_SIZE -> prom_we, dn_addr=addr-PROM_BASE.
    - Any other address, including addr[24:16]!=0 -> no we, overflow flag set.
  - Latency: we, dn_addr and dn_data are valid exactly 1 cycle after the ioctl_wr cycle. The we pulse is 1 cycle wide.
  - Address bits above bit 15 of the relative address are dropped.
  - byte_count increments once per in-range write.
  - Fall -> CHECK. A write in the same cycle as fall is still accepted.
- CHECK: 1 cycle.
  - If overflow=0 and byte_count == CPU_ROM_SIZE+GFX_SIZE+PROM_SIZE -> HOLD.
  - Otherwise -> ERR.
- HOLD: core_reset=1. hold counter counts 0..HOLD_CYCLES-1, then -> RUN.
- RUN: core_reset=0, load_ok=1.
- ERR: core_reset=1, load_err=1. Only exit is a new download.
- Rise from HOLD, RUN or ERR -> LOAD. Entering LOAD reasserts core_reset in the same cycle the state is entered.
- ioctl_wr while ioctl_download=0 is ignored: no we, no count.
- Duplicate writes to one address count twice. The resulting length mismatch -> ERR. This is intended.
- Synchronous reset mid-load aborts to IDLE and drops any pending we. The core stays in reset until a full new download.
- At most one *_we is high in any cycle.

Decomposition:
- Package galaxian_dl_pkg:
  - state enum
  - region enum (NONE, CPU, GFX, PROM)
  - localparam EXPECTED_LEN = CPU_ROM_SIZE+GFX_SIZE+PROM_SIZE
- One sub-module, galaxian_dl_decode: combinational address -> region and relative address. It is instantiated once and is separately unit-testable.
- FSM, counters and output registers live in galaxian_dl_ctrl.

Test Plan:
- Full image: download with 0x5020 sequential bytes, addresses 0x0000-0x501F.
  - byte_count=0x5020.
  - cpu_rom_we 16384x, gfx_rom_we 4096x, prom_we 32x.
  - Write at addr 0x4005 gives gfx_rom_we, dn_addr=0x0005.
  - core_reset falls exactly 1+1+1024 cycles after fall (CHECK plus HOLD).
  - load_ok=1.
- Short image: stop after 0x5000 bytes -> ERR, load_err=1, core_reset stays 1, no prom_we seen.
- Out-of-range: valid image plus one write at 0x6000 -> no we for that byte, byte_count=0x5020, ERR.
- Reload from RUN: second full download.
  - core_reset=1 from the rise cycle.
  - load_ok clears on entry to LOAD.
  - Ends RUN again with byte_count=0x5020.
- Reset mid-load: assert reset after 100 bytes.
  - Next cycle state IDLE, byte_count=0, no we.
  - Following writes with ioctl_download held high and no new rise are ignored.
- Stray strobe: ioctl_wr=1 with ioctl_download=0 in RUN -> no we, count unchanged, core_reset stays 0.
